// File: rtl/mdr_mem_port.sv
// mdr_mem_port: MAR/MDR pair with a memory-side read/write sequencer for the
// Mini SRC datapath. MAR and MDR load from the shared bus while idle. A Read or
// Write starts a req/ack handshake with the RAM. Each transfer ends with a
// one-cycle done pulse, either on ack or on timeout (sticky err).
//
// Ports:
//   clk, clr       rising-edge clock, asynchronous active-high reset
//   BusMuxOut      shared bus value (MAR keeps the low ADDR_W bits)
//   MARin, MDRin   load MAR / MDR from the bus (idle only)
//   Read, Write    start a transfer (Read wins if both are asserted)
//   mem_rdata      RAM read data, valid with mem_ack
//   mem_ack        RAM completion strobe
//   mem_req        transfer request to the RAM
//   mem_we         1 = write, 0 = read (valid while mem_req)
//   mem_addr       MAR contents
//   mem_wdata      MDR contents
//   BusMuxInMDR    MDR contents to the bus multiplexer
//   busy           transfer in progress (XFER and FIN)
//   done           one-cycle pulse at the end of every transfer
//   err            sticky timeout flag, cleared by the next accepted command
module mdr_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The timer only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [TW-1:0]     timer_q;
  logic              req_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // MAR intentionally drops the upper bus bits.
  logic unused_bus_hi;
  assign unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      timer_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Loads land on the same edge the command is accepted, so a command
          // issued alongside MARin/MDRin sees the new value on mem_addr/mem_wdata.
          if (MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr_q <= BusMuxOut;
          if (Read || Write) begin
            state_q <= XFER;
            req_q   <= 1'b1;
            we_q    <= !Read;
            busy_q  <= 1'b1;
            timer_q <= '0;
            err_q   <= 1'b0;
          end
        end
        XFER: begin
          // Ack has priority over a timeout on the same edge.
          if (mem_ack) begin
            if (!we_q) mdr_q <= mem_rdata;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (timer_q == TMAX) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign BusMuxInMDR = mdr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
module tb_mdr_mem_port;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              clr;
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin, MDRin, Read, Write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, BusMuxInMDR;
  logic              busy, done, err;

  mdr_mem_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .BusMuxOut  (BusMuxOut),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .Read       (Read),
    .Write      (Write),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .BusMuxInMDR(BusMuxInMDR),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural registers only.
  logic [ADDR_W-1:0] m_mar;
  logic [DATA_W-1:0] m_mdr;
  logic              m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  64'(mem_req), 64'(0));
    chk({tag, "_we"},   64'(mem_we), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wd"},   64'(mem_wdata), 64'(0));
    chk({tag, "_mdr"},  64'(BusMuxInMDR), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"},  64'(err), 64'(0));
  endtask

  task automatic clear_inputs();
    MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
  endtask

  // Called just after a negedge; idle register load without a command.
  task automatic load(input logic ml, input logic dl, input logic [DATA_W-1:0] bus);
    MARin = ml; MDRin = dl; BusMuxOut = bus;
    @(posedge clk);
    if (ml) m_mar = bus[ADDR_W-1:0];
    if (dl) m_mdr = bus;
    @(negedge clk);
    clear_inputs();
    chk("load_addr", 64'(mem_addr), 64'(m_mar));
    chk("load_mdr",  64'(BusMuxInMDR), 64'(m_mdr));
    chk("load_busy", 64'(busy), 64'(0));
  endtask

  // One full transfer. ack_k: cycle (1-based, counted while mem_req is high)
  // in which the RAM acks; values outside 1..TIMEOUT mean no ack in time.
  // noise: hammer commands and loads while busy, all of which must be ignored.
  task automatic xfer(input logic rd, input logic wr, input logic ml, input logic dl,
                      input logic [DATA_W-1:0] bus, input int ack_k,
                      input logic [DATA_W-1:0] rdata, input logic noise);
    int   cnt;
    int   expk;
    logic acked;
    logic is_read;
    cnt = 0;
    MARin = ml; MDRin = dl; BusMuxOut = bus; Read = rd; Write = wr;
    @(posedge clk);
    if (ml) m_mar = bus[ADDR_W-1:0];
    if (dl) m_mdr = bus;
    m_err   = 1'b0;
    is_read = rd;
    acked   = (ack_k >= 1) && (ack_k <= TIMEOUT);
    expk    = acked ? ack_k : TIMEOUT;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (mem_req !== 1'b1) break;
      cnt++;
      chk("xfer_we",   64'(mem_we), 64'(!is_read));
      chk("xfer_addr", 64'(mem_addr), 64'(m_mar));
      chk("xfer_wd",   64'(mem_wdata), 64'(m_mdr));
      chk("xfer_busy", 64'(busy), 64'(1));
      chk("xfer_done", 64'(done), 64'(0));
      if (cnt == 1) chk("xfer_err_clr", 64'(err), 64'(0));
      mem_ack   = (cnt == ack_k);
      mem_rdata = mem_ack ? rdata : $urandom;
      if (noise) begin
        Write = 1'b1; MDRin = 1'b1; MARin = 1'b1; BusMuxOut = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (acked && is_read) m_mdr = rdata;
    m_err = !acked;
    chk("req_cycles", 64'(cnt), 64'(expk));
    chk("fin_req",  64'(mem_req), 64'(0));
    chk("fin_done", 64'(done), 64'(1));
    chk("fin_busy", 64'(busy), 64'(1));
    chk("fin_mdr",  64'(BusMuxInMDR), 64'(m_mdr));
    chk("fin_err",  64'(err), 64'(m_err));
    if (noise) Read = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk("post_done", 64'(done), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_req",  64'(mem_req), 64'(0));
    chk("post_mdr",  64'(BusMuxInMDR), 64'(m_mdr));
    chk("post_addr", 64'(mem_addr), 64'(m_mar));
    chk("post_err",  64'(err), 64'(m_err));
  endtask

  initial begin
    clear_inputs();
    BusMuxOut = '0; mem_rdata = '0; mem_ack = 1'b0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    clr = 1'b1;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_rel");

    // Reset in the middle of a transfer: asynchronous, no done pulse.
    load(1'b1, 1'b1, 32'h0000_0155);
    Read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    chk("mid_req", 64'(mem_req), 64'(1));
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk_all_zero("async_clr");
    @(negedge clk);
    clr = 1'b0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    @(negedge clk);
    chk_all_zero("after_clr");

    // Read at 0x1F3, ack in the third request cycle.
    load(1'b1, 1'b0, 32'h0000_01F3);
    xfer(1'b1, 1'b0, 1'b0, 1'b0, '0, 3, 32'hACADACAD, 1'b0);
    chk("t2_addr", 64'(mem_addr), 64'h1F3);
    chk("t2_mdr",  64'(BusMuxInMDR), 64'hACADACAD);

    // Write MDR=0x12345678 to 0x00A, ack in the first cycle.
    load(1'b0, 1'b1, 32'h12345678);
    load(1'b1, 1'b0, 32'h0000_000A);
    xfer(1'b0, 1'b1, 1'b0, 1'b0, '0, 1, 32'hFFFF0000, 1'b0);
    chk("t3_mdr", 64'(BusMuxInMDR), 64'h12345678);
    chk("t3_err", 64'(err), 64'(0));

    // Timeout, then the next command clears err.
    xfer(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 32'h0, 1'b0);
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_mdr", 64'(BusMuxInMDR), 64'h12345678);
    xfer(1'b1, 1'b0, 1'b0, 1'b0, '0, 2, 32'h0BADF00D, 1'b0);
    chk("t4_err_clr", 64'(err), 64'(0));

    // Ack on the timeout edge: ack wins.
    xfer(1'b1, 1'b0, 1'b0, 1'b0, '0, TIMEOUT, 32'hC0FFEE11, 1'b0);
    chk("tmo_edge_err", 64'(err), 64'(0));

    // Read+Write together performs a read; busy-time commands are ignored.
    xfer(1'b1, 1'b1, 1'b0, 1'b0, '0, 4, 32'h5A5A1234, 1'b1);
    chk("t5_mdr", 64'(BusMuxInMDR), 64'h5A5A1234);

    // Upper address bits dropped; stray ack while idle has no effect.
    load(1'b1, 1'b0, 32'hFFFFFFFF);
    chk("t6_addr", 64'(mem_addr), 64'h1FF);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_done", 64'(done), 64'(0));
    chk("idle_ack_busy", 64'(busy), 64'(0));
    chk("idle_ack_req",  64'(mem_req), 64'(0));
    chk("idle_ack_mdr",  64'(BusMuxInMDR), 64'(m_mdr));

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      if (($urandom % 3) == 0) load(1'($urandom), 1'($urandom), $urandom);
      xfer(rd, wr, 1'($urandom), 1'($urandom), $urandom,
           int'($urandom_range(1, TIMEOUT + 2)), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
